seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_detect_ctrl_if.sv | 30 +++
 rtl/seq_pattern_matcher.sv | 50 +++++
 rtl/seq_detect_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and defaults.
`timescale 1ns/1ps
package seq_det_pkg;

    // Controller states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_e;

    // Pattern loaded at reset unless overridden by the PAT_RST parameter.
    localparam logic [3:0] PAT_RST_DEFAULT = 4'b1001;

    // Number of bits needed in the window before a compare is meaningful.
    localparam int FILL_FULL = 4;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Byte-stream, configuration and frame-result signals of the detector bundled together.
`timescale 1ns/1ps
interface seq_detect_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             cfg_we;
    logic [3:0]       cfg_pattern;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             match;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;
    logic             busy;

    // Producer / consumer side that drives bytes and accepts results.
    modport master (
        output cfg_we, cfg_pattern, in_valid, in_data, in_last, res_ready,
        input  in_ready, match, res_valid, res_count, res_ovf, busy
    );

    // Detector side.
    modport slave (
        input  cfg_we, cfg_pattern, in_valid, in_data, in_last, res_ready,
        output in_ready, match, res_valid, res_count, res_ovf, busy
    );
endinterface

// File: rtl/seq_pattern_matcher.sv
// 4-bit sliding-window matcher with a fill counter and a registered match flag.
`timescale 1ns/1ps
module seq_pattern_matcher
    import seq_det_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    input  logic       clear_i,
    input  logic [3:0] pattern_i,
    output logic       match_o
);
    logic [3:0] window_q, window_d;
    logic [2:0] fill_q, fill_d;
    logic       match_q, match_d;

    // Shift the new bit into the window; a match needs a full window, history is never
    // reset on a match so overlapping occurrences are all reported.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        match_d  = 1'b0;
        if (clear_i) begin
            window_d = '0;
            fill_d   = '0;
        end else if (bit_valid_i) begin
            window_d = {window_q[2:0], bit_i};
            if (fill_q != 3'(FILL_FULL)) begin
                fill_d = fill_q + 3'd1;
            end
            match_d = (fill_q >= 3'(FILL_FULL - 1)) && (window_d == pattern_i);
        end
    end

    // Window, fill count and match flag registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
        end
    end

    assign match_o = match_q;
endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: serializes bytes MSB first into the matcher, counts matches per frame
// and reports the count once the frame's last byte has drained.
`timescale 1ns/1ps
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int         CNT_W   = 6,
    parameter logic [3:0] PAT_RST = PAT_RST_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_we,
    input  logic [3:0]       i_cfg_pattern,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [7:0]       i_in_data,
    input  logic             i_in_last,
    output logic             o_match,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [CNT_W-1:0] o_res_count,
    output logic             o_res_ovf,
    output logic             o_busy
);
    state_e           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       pattern_q, pattern_d;
    logic             bit_valid;
    logic             res_hs;
    logic             in_ready;

    assign res_hs = (state_q == REPORT) && i_res_ready;

    // Next-state logic: accept a byte in IDLE or on the bit-0 cycle of SHIFT so
    // consecutive bytes stream without a bubble.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        last_d    = last_q;
        bit_valid = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (i_in_valid) begin
                    shreg_d = i_in_data;
                    last_d  = i_in_last;
                    idx_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                if (idx_q == 3'd0) begin
                    in_ready = 1'b1;
                    if (i_in_valid) begin
                        shreg_d = i_in_data;
                        last_d  = i_in_last;
                        idx_d   = 3'd7;
                    end else if (last_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            // One cycle so the match produced by the frame's final bit lands in the count.
            DRAIN: begin
                state_d = REPORT;
            end
            REPORT: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Per-frame counter with saturation and sticky overflow; pattern writable only in IDLE.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        pattern_d = pattern_q;
        if (res_hs) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (o_match) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if ((state_q == IDLE) && i_cfg_we) begin
            pattern_d = i_cfg_pattern;
        end
    end

    // Controller state, datapath and configuration registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            pattern_q <= PAT_RST;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            pattern_q <= pattern_d;
        end
    end

    seq_pattern_matcher u_matcher (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .bit_i       (shreg_q[idx_q]),
        .bit_valid_i (bit_valid),
        .clear_i     (res_hs),
        .pattern_i   (pattern_q),
        .match_o     (o_match)
    );

    assign o_in_ready  = in_ready;
    assign o_res_valid = (state_q == REPORT);
    assign o_res_count = cnt_q;
    assign o_res_ovf   = ovf_q;
    assign o_busy      = (state_q != IDLE);
endmodule
